// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic family: FSM state,
// mode encoding, counter sizing and the 2:1 mux primitive the cells are built from.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // The bit counter only has to hold WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

    // i[1] is selected when s = 1, matching the {i1, i0} ordering used by the cells.
    function automatic logic mux2(input logic [1:0] i, input logic s);
        return i[s];
    endfunction

endpackage

// File: rtl/serial_addsub_mux_if.sv
// Start/busy/done handshake and operand/result bus of serial_addsub_mux.
// The controller drives through master; the arithmetic unit sits on slave.
interface serial_addsub_mux_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output start, mode, a, b,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, result, cout, ovf
    );
endinterface

// File: rtl/fas_mux_cell.sv
// One-bit full adder / full subtractor built from three 2:1 muxes.
// mode = MODE_SUB turns the carry path into a borrow path for a - b.
module fas_mux_cell
    import serial_arith_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic c,
    input  logic mode,
    output logic y,
    output logic c_next
);
    logic t;
    logic a_eff;

    // Subtract borrows exactly where an adder would carry with a inverted.
    assign a_eff  = a_i ^ (mode == MODE_SUB);

    assign t      = mux2({~b_i, b_i}, a_i);
    assign y      = mux2({~t, t}, c);
    assign c_next = mux2({a_eff | b_i, a_eff & b_i}, c);

endmodule

// File: rtl/serial_addsub_mux.sv
// Bit-serial adder/subtractor: LSB-first through one fas_mux_cell and a carry flop.
// Define SERIAL_ADDSUB_OVF_EN to build the signed-overflow output; otherwise ovf is 0.
module serial_addsub_mux
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_addsub_mux_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;

    logic y;
    logic c_next;
    logic load;
    logic last;

    assign load = bus.start && (state_q != SHIFT);
    assign last = (state_q == SHIFT) && (cnt_q == '0);

    fas_mux_cell u_cell (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .c      (c_q),
        .mode   (mode_q),
        .y      (y),
        .c_next (c_next)
    );

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = bus.start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == SHIFT);
        bus.done = (state_q == DONE);
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;

        if (load) begin
            a_d    = bus.a;
            b_d    = bus.b;
            mode_d = bus.mode;
            c_d    = 1'b0;
            cnt_d  = CW'(WIDTH - 1);
        end else if (state_q == SHIFT) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            c_d   = c_next;
            cnt_d = cnt_q - 1'b1;
            acc_d = (WIDTH-1)'({y, acc_q} >> 1);
            // The partial sum stays internal; result only moves on the final bit.
            if (last) begin
                result_d = {y, acc_q};
                cout_d   = c_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= MODE_ADD;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    assign bus.result = result_q;
    assign bus.cout   = cout_q;

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_q, ovf_d;

    // On the last bit c_q is the carry/borrow into the MSB and c_next the one out of it.
    always_comb begin
        ovf_d = ovf_q;
        if (last) ovf_d = c_q ^ c_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub_mux.sv
// Self-checking bench for serial_addsub_mux (WIDTH=8): directed cases, busy-ignore,
// back-to-back, mid-operation reset and random operands against an arithmetic model.
module tb_serial_addsub_mux;
    import serial_arith_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    logic [W-1:0] last_res;
    logic         last_cout;
    logic         last_ovf;

    serial_addsub_mux_if #(.WIDTH(W)) bus ();

    serial_addsub_mux #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Plain-arithmetic reference: unsigned sum/difference plus sign-rule overflow.
    function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic m,
                                  output logic [W-1:0] r, output logic co, output logic ov);
        int unsigned ua = av;
        int unsigned ub = bv;
        int unsigned s;
        if (m == MODE_ADD) begin
            s  = ua + ub;
            r  = s[W-1:0];
            co = (s >= (1 << W));
            ov = (av[W-1] == bv[W-1]) && (r[W-1] != av[W-1]);
        end else begin
            s  = ua - ub;
            r  = s[W-1:0];
            co = (ua < ub);
            ov = (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]);
        end
`ifndef SERIAL_ADDSUB_OVF_EN
        ov = 1'b0;
`endif
    endfunction

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic m);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        bus.mode  = m;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.mode  = 1'($urandom);
    endtask

    // Follows one operation from the cycle after acceptance to its DONE cycle.
    task automatic monitor(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic m, input int glitch_at);
        logic [W-1:0] er;
        logic         ec;
        logic         eo;
        model(av, bv, m, er, ec, eo);
        for (int n = 0; n <= W; n++) begin
            if (n > 0) @(negedge clk);
            tests++;
            if ({bus.busy, bus.done} !== {(n < W), (n == W)}) begin
                fails++;
                $display("FAIL %s timing cycle %0d: busy/done=%b%b expected %b%b",
                         name, n, bus.busy, bus.done, (n < W), (n == W));
            end
            if (n < W) begin
                tests++;
                if ({bus.result, bus.cout, bus.ovf} !== {last_res, last_cout, last_ovf}) begin
                    fails++;
                    $display("FAIL %s hold cycle %0d: result/cout/ovf=%h/%b/%b expected %h/%b/%b",
                             name, n, bus.result, bus.cout, bus.ovf, last_res, last_cout, last_ovf);
                end
            end
            if (n == glitch_at) begin
                bus.start = 1'b1;
                bus.a     = '1;
                bus.b     = '1;
                bus.mode  = MODE_ADD;
            end else if (n == glitch_at + 1) begin
                bus.start = 1'b0;
            end
        end
        tests++;
        if (bus.result !== er) begin
            fails++;
            $display("FAIL %s result: got %h expected %h", name, bus.result, er);
        end
        tests++;
        if (bus.cout !== ec) begin
            fails++;
            $display("FAIL %s cout: got %b expected %b", name, bus.cout, ec);
        end
        tests++;
        if (bus.ovf !== eo) begin
            fails++;
            $display("FAIL %s ovf: got %b expected %b", name, bus.ovf, eo);
        end
        last_res  = er;
        last_cout = ec;
        last_ovf  = eo;
    endtask

    task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic m);
        launch(av, bv, m);
        monitor(name, av, bv, m, -1);
        @(negedge clk);
    endtask

    task automatic check_quiet(input string name, input int cycles);
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            tests++;
            if ({bus.busy, bus.done} !== 2'b00) begin
                fails++;
                $display("FAIL %s quiet cycle %0d: busy/done=%b%b expected 00",
                         name, n, bus.busy, bus.done);
            end
        end
    endtask

    task automatic check_reset_values(input string name);
        tests++;
        if ({bus.busy, bus.done, bus.result, bus.cout, bus.ovf} !== {2'b00, {W{1'b0}}, 2'b00}) begin
            fails++;
            $display("FAIL %s: busy/done/result/cout/ovf=%b/%b/%h/%b/%b expected 0/0/00/0/0",
                     name, bus.busy, bus.done, bus.result, bus.cout, bus.ovf);
        end
        last_res  = '0;
        last_cout = 1'b0;
        last_ovf  = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.mode  = MODE_ADD;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_values("reset");
        check_quiet("reset_idle", 2);
    endtask

    task automatic test_directed();
        run_op("add_5a_33", 8'h5A, 8'h33, MODE_ADD);
        run_op("add_ff_01", 8'hFF, 8'h01, MODE_ADD);
        run_op("add_7f_01", 8'h7F, 8'h01, MODE_ADD);
        run_op("add_ff_ff", 8'hFF, 8'hFF, MODE_ADD);
        run_op("sub_10_01", 8'h10, 8'h01, MODE_SUB);
        run_op("sub_01_02", 8'h01, 8'h02, MODE_SUB);
        run_op("sub_80_01", 8'h80, 8'h01, MODE_SUB);
        run_op("sub_00_ff", 8'h00, 8'hFF, MODE_SUB);
        run_op("sub_equal", 8'hA7, 8'hA7, MODE_SUB);
    endtask

    task automatic test_busy_ignore();
        launch(8'h12, 8'h34, MODE_ADD);
        monitor("busy_ignore", 8'h12, 8'h34, MODE_ADD, 2);
        check_quiet("busy_ignore_after", W + 3);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] av;
        logic [W-1:0] bv;
        int           t1;
        av = W'($urandom);
        bv = W'($urandom);
        launch(av, bv, MODE_SUB);
        monitor("b2b_first", av, bv, MODE_SUB, -1);
        t1 = cyc;
        launch(8'h01, 8'h01, MODE_ADD);
        monitor("b2b_second", 8'h01, 8'h01, MODE_ADD, -1);
        tests++;
        if (cyc - t1 !== W + 1) begin
            fails++;
            $display("FAIL b2b_gap: done pulses %0d cycles apart expected %0d", cyc - t1, W + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic         m;
        for (int i = 0; i < 30; i++) begin
            av = W'($urandom);
            bv = W'($urandom);
            m  = 1'($urandom);
            run_op($sformatf("rand_%0d", i), av, bv, m);
        end
    endtask

    task automatic test_reset_mid();
        run_op("pre_abort", 8'hC3, 8'h5E, MODE_ADD);
        launch(8'hA5, 8'h3C, MODE_ADD);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("reset_mid");
        check_quiet("reset_mid_no_done", W + 4);
        run_op("after_abort", 8'h0F, 8'hF1, MODE_SUB);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
